// File: rtl/image_half_pkg.sv
// Width helpers and adder-width constants shared by the image half-downsampler blocks.
package image_half_pkg;

    localparam int PAIR_EXTRA_BITS = 1;
    localparam int SUM_EXTRA_BITS  = 2;

    function automatic int x_w(input int new_width);
        return $clog2(2 * new_width);
    endfunction

    function automatic int y_w(input int new_height);
        return $clog2(2 * new_height);
    endfunction

    function automatic int addr_w(input int new_width, input int new_height);
        return $clog2(new_width) + $clog2(new_height);
    endfunction

    function automatic int pair_w(input int bit_depth);
        return bit_depth + PAIR_EXTRA_BITS;
    endfunction

    function automatic int sum_w(input int bit_depth);
        return bit_depth + SUM_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/half_row_sum_buffer.sv
// One-row store of horizontal pixel-pair sums, one synchronous write port and a combinational read port.
module half_row_sum_buffer #(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 9,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // No reset: every entry is rewritten on an even row before an odd row reads it.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/image_half_downsampler.sv
// Streaming 2:1 X/Y downsampler for raster pixel streams with linear write-address output.
// IMAGE_HALF_AVERAGE_EN selects 2x2 box averaging; otherwise top-left-pixel decimation.
module image_half_downsampler
    import image_half_pkg::*;
#(
    parameter int BIT_DEPTH  = 8,
    parameter int NEW_WIDTH  = 32,
    parameter int NEW_HEIGHT = NEW_WIDTH
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic [BIT_DEPTH-1:0]                   data_in,
    input  logic [x_w(NEW_WIDTH)-1:0]              data_x_in,
    input  logic [y_w(NEW_HEIGHT)-1:0]             data_y_in,
    input  logic                                   data_valid_in,
    output logic [BIT_DEPTH-1:0]                   data_out,
    output logic [addr_w(NEW_WIDTH,NEW_HEIGHT)-1:0] data_addr_out,
    output logic                                   data_valid_out,
    output logic                                   done_out
);

    localparam int ADDR_W = addr_w(NEW_WIDTH, NEW_HEIGHT);
    localparam int IN_W   = 2 * NEW_WIDTH;
    localparam int IN_H   = 2 * NEW_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NEW_WIDTH * NEW_HEIGHT - 1);

    logic                 in_range;
    logic                 accept;
    logic                 emit;
    logic [ADDR_W-1:0]    addr_next;
    logic [BIT_DEPTH-1:0] pix_next;

    assign in_range  = (32'(data_x_in) < IN_W) && (32'(data_y_in) < IN_H);
    assign accept    = data_valid_in && in_range && !done_out;
    assign addr_next = ADDR_W'(32'(data_y_in >> 1) * NEW_WIDTH + 32'(data_x_in >> 1));

`ifdef IMAGE_HALF_AVERAGE_EN
    localparam int COL_W  = $clog2(NEW_WIDTH);
    localparam int PAIR_W = pair_w(BIT_DEPTH);
    localparam int SUM_W  = sum_w(BIT_DEPTH);

    logic [BIT_DEPTH-1:0] held_pixel;
    logic [PAIR_W-1:0]    pair_sum;
    logic [PAIR_W-1:0]    row_pair;
    logic [SUM_W-1:0]     box_sum;
    logic [COL_W-1:0]     col;
    logic                 row_wr_en;

    assign col       = COL_W'(data_x_in >> 1);
    assign pair_sum  = PAIR_W'(held_pixel) + PAIR_W'(data_in);
    assign row_wr_en = accept && data_x_in[0] && !data_y_in[0];
    assign box_sum   = SUM_W'(row_pair) + SUM_W'(pair_sum);
    assign emit      = accept && data_x_in[0] && data_y_in[0];
    // Divide by four by truncation; the extra sum bits keep an all-max block from wrapping.
    assign pix_next  = box_sum[SUM_W-1:2];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            held_pixel <= '0;
        end else if (accept && !data_x_in[0]) begin
            held_pixel <= data_in;
        end
    end

    half_row_sum_buffer #(
        .DEPTH (NEW_WIDTH),
        .WIDTH (PAIR_W)
    ) u_row_buf (
        .clk_in  (clk_in),
        .wr_en   (row_wr_en),
        .wr_addr (col),
        .wr_data (pair_sum),
        .rd_addr (col),
        .rd_data (row_pair)
    );
`else
    assign emit     = accept && !data_x_in[0] && !data_y_in[0];
    assign pix_next = data_in;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            data_out       <= '0;
            data_addr_out  <= '0;
            data_valid_out <= 1'b0;
            done_out       <= 1'b0;
        end else begin
            data_valid_out <= emit;
            if (emit) begin
                data_out      <= pix_next;
                data_addr_out <= addr_next;
                if (addr_next == LAST_ADDR) begin
                    done_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_image_half_downsampler.sv
// Scoreboard bench for image_half_downsampler; expectations follow IMAGE_HALF_AVERAGE_EN if defined.
module tb_image_half_downsampler;

    localparam int NW = 32;
    localparam int NH = 32;
    localparam int N_OUT = NW * NH;

`ifdef IMAGE_HALF_AVERAGE_EN
    localparam logic [7:0] BLK_A_EXP  = 8'd25;
    localparam logic [7:0] XY_A33_EXP = 8'd5;
`else
    localparam logic [7:0] BLK_A_EXP  = 8'd10;
    localparam logic [7:0] XY_A33_EXP = 8'd4;
`endif

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic [7:0] data_in = '0;
    logic [5:0] data_x_in = '0;
    logic [5:0] data_y_in = '0;
    logic       data_valid_in = 1'b0;
    logic [7:0] data_out;
    logic [9:0] data_addr_out;
    logic       data_valid_out;
    logic       done_out;

    image_half_downsampler #(
        .BIT_DEPTH  (8),
        .NEW_WIDTH  (NW),
        .NEW_HEIGHT (NH)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .data_in        (data_in),
        .data_x_in      (data_x_in),
        .data_y_in      (data_y_in),
        .data_valid_in  (data_valid_in),
        .data_out       (data_out),
        .data_addr_out  (data_addr_out),
        .data_valid_out (data_valid_out),
        .done_out       (done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] data;
        logic [9:0] addr;
        logic       done;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [9:0] addr;
    } out_t;

    exp_t       sb[$];
    out_t       cap[$];
    out_t       cap_ref[$];
    logic [7:0] img [64][64];
    int         num_checks = 0;
    int         num_errors = 0;
    int         cyc = 0;
    int         out_count = 0;
    int         done_rises = 0;
    bit         exp_done = 1'b0;
    logic       prev_done = 1'b0;

    // Output monitor: every strobe pops the scoreboard, including latency.
    always @(posedge clk_in) begin
        exp_t e;
        cyc++;
        #1;
        if (rst_in) begin
            if (done_out && !prev_done) done_rises++;
            prev_done = done_out;
            if (data_valid_out) begin
                out_count++;
                cap.push_back('{data_out, data_addr_out});
                num_checks++;
                if (sb.size() == 0) begin
                    num_errors++;
                    $display("FAIL unexpected_strobe: got addr %0d data %0d, required no strobe",
                             data_addr_out, data_out);
                end else begin
                    e = sb.pop_front();
                    if (data_out !== e.data) begin
                        num_errors++;
                        $display("FAIL out_data addr %0d: got %0d, required %0d", e.addr, data_out, e.data);
                    end
                    num_checks++;
                    if (data_addr_out !== e.addr) begin
                        num_errors++;
                        $display("FAIL out_addr: got %0d, required %0d", data_addr_out, e.addr);
                    end
                    num_checks++;
                    if (done_out !== e.done) begin
                        num_errors++;
                        $display("FAIL out_done addr %0d: got %0b, required %0b", e.addr, done_out, e.done);
                    end
                    num_checks++;
                    if (cyc !== e.cyc + 1) begin
                        num_errors++;
                        $display("FAIL out_latency addr %0d: got %0d cycles, required 1", e.addr, cyc - e.cyc);
                    end
                end
            end
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic drive_pix(input int x, input int y);
        exp_t e;
        int   s;
        @(negedge clk_in);
        data_in       = img[y][x];
        data_x_in     = 6'(x);
        data_y_in     = 6'(y);
        data_valid_in = 1'b1;
        if (!exp_done) begin
`ifdef IMAGE_HALF_AVERAGE_EN
            if ((x % 2 == 1) && (y % 2 == 1)) begin
                s = int'(img[y-1][x-1]) + int'(img[y-1][x]) + int'(img[y][x-1]) + int'(img[y][x]);
                e.data = 8'(s / 4);
`else
            if ((x % 2 == 0) && (y % 2 == 0)) begin
                e.data = img[y][x];
`endif
                e.addr = 10'((y / 2) * NW + x / 2);
                e.done = (e.addr == 10'(N_OUT - 1));
                e.cyc  = cyc;
                if (e.done) exp_done = 1'b1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            data_valid_in = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_in);
        rst_in        = 1'b0;
        data_valid_in = 1'b0;
        sb.delete();
        cap.delete();
        exp_done   = 1'b0;
        out_count  = 0;
        done_rises = 0;
        repeat (n) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic run_frame(input int gap_pct);
        for (int y = 0; y < 2 * NH; y++) begin
            for (int x = 0; x < 2 * NW; x++) begin
                while (int'($urandom_range(99)) < gap_pct) idle(1);
                drive_pix(x, y);
            end
        end
        idle(3);
    endtask

    task automatic fill_img(input int pattern);
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++)
                case (pattern)
                    0:       img[y][x] = 8'h80;
                    1:       img[y][x] = 8'(x + y);
                    default: img[y][x] = 8'($urandom_range(255));
                endcase
    endtask

    task automatic test_frame_end(input string name);
        num_checks++;
        if (out_count !== N_OUT) begin
            num_errors++;
            $display("FAIL %s_count: got %0d strobes, required %0d", name, out_count, N_OUT);
        end
        num_checks++;
        if (done_out !== 1'b1) begin
            num_errors++;
            $display("FAIL %s_done: got %0b, required 1", name, done_out);
        end
        num_checks++;
        if (done_rises !== 1) begin
            num_errors++;
            $display("FAIL %s_done_rises: got %0d, required 1", name, done_rises);
        end
        num_checks++;
        if (sb.size() !== 0) begin
            num_errors++;
            $display("FAIL %s_pending: got %0d outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        rst_in        = 1'b0;
        data_valid_in = 1'b0;
        repeat (5) @(negedge clk_in);
        num_checks++;
        if (data_out !== 8'd0) begin
            num_errors++;
            $display("FAIL reset_data: got %0d, required 0", data_out);
        end
        num_checks++;
        if (data_addr_out !== 10'd0) begin
            num_errors++;
            $display("FAIL reset_addr: got %0d, required 0", data_addr_out);
        end
        num_checks++;
        if (data_valid_out !== 1'b0) begin
            num_errors++;
            $display("FAIL reset_valid: got %0b, required 0", data_valid_out);
        end
        num_checks++;
        if (done_out !== 1'b0) begin
            num_errors++;
            $display("FAIL reset_done: got %0b, required 0", done_out);
        end
        rst_in = 1'b1;
        idle(10);
        num_checks++;
        if (out_count !== 0 || data_valid_out !== 1'b0) begin
            num_errors++;
            $display("FAIL idle_no_strobe: got %0d strobes, required 0", out_count);
        end
    endtask

    task automatic test_const_frame();
        do_reset(3);
        fill_img(0);
        run_frame(0);
        test_frame_end("const");
        drive_pix(0, 0);
        drive_pix(1, 0);
        drive_pix(0, 1);
        drive_pix(1, 1);
        idle(3);
        num_checks++;
        if (out_count !== N_OUT) begin
            num_errors++;
            $display("FAIL after_done_ignored: got %0d strobes, required %0d", out_count, N_OUT);
        end
    endtask

    task automatic test_block();
        do_reset(3);
        img[0][0] = 8'd10;  img[0][1] = 8'd20;
        img[1][0] = 8'd30;  img[1][1] = 8'd41;
        img[0][2] = 8'd255; img[0][3] = 8'd255;
        img[1][2] = 8'd255; img[1][3] = 8'd255;
        drive_pix(0, 0);
        drive_pix(1, 0);
        drive_pix(0, 1);
        drive_pix(1, 1);
        idle(4);
        num_checks++;
        if (cap.size() !== 1 || cap[0].data !== BLK_A_EXP || cap[0].addr !== 10'd0) begin
            num_errors++;
            $display("FAIL block_a: got %0d outputs, first data %0d addr %0d, required 1 output data %0d addr 0",
                     cap.size(), cap[0].data, cap[0].addr, BLK_A_EXP);
        end
        num_checks++;
        if (data_out !== BLK_A_EXP || data_valid_out !== 1'b0) begin
            num_errors++;
            $display("FAIL block_hold: got data %0d valid %0b, required data %0d valid 0",
                     data_out, data_valid_out, BLK_A_EXP);
        end
        drive_pix(2, 0);
        drive_pix(3, 0);
        drive_pix(2, 1);
        drive_pix(3, 1);
        idle(3);
        num_checks++;
        if (cap.size() !== 2 || cap[1].data !== 8'd255 || cap[1].addr !== 10'd1) begin
            num_errors++;
            $display("FAIL block_sat: got %0d outputs, second data %0d addr %0d, required 2 outputs data 255 addr 1",
                     cap.size(), cap[1].data, cap[1].addr);
        end
    endtask

    task automatic test_xy_pattern();
        logic [7:0] found;
        bit         seen;
        do_reset(3);
        fill_img(1);
        run_frame(0);
        test_frame_end("xy");
        seen  = 1'b0;
        found = '0;
        foreach (cap[i]) begin
            if (cap[i].addr == 10'd33) begin
                seen  = 1'b1;
                found = cap[i].data;
            end
        end
        num_checks++;
        if (!seen || found !== XY_A33_EXP) begin
            num_errors++;
            $display("FAIL xy_addr33: got seen=%0b data %0d, required data %0d", seen, found, XY_A33_EXP);
        end
    endtask

    task automatic test_gaps();
        do_reset(3);
        fill_img(2);
        run_frame(0);
        cap_ref = cap;
        do_reset(3);
        run_frame(50);
        test_frame_end("gaps");
        num_checks++;
        if (cap.size() !== cap_ref.size()) begin
            num_errors++;
            $display("FAIL gaps_len: got %0d, required %0d", cap.size(), cap_ref.size());
        end else begin
            foreach (cap[i]) begin
                num_checks++;
                if (cap[i].data !== cap_ref[i].data || cap[i].addr !== cap_ref[i].addr) begin
                    num_errors++;
                    $display("FAIL gaps_seq[%0d]: got data %0d addr %0d, required data %0d addr %0d",
                             i, cap[i].data, cap[i].addr, cap_ref[i].data, cap_ref[i].addr);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        do_reset(3);
        fill_img(2);
        for (int y = 0; y < 17; y++)
            for (int x = 0; x < 2 * NW; x++)
                drive_pix(x, y);
        for (int x = 0; x < 10; x++) drive_pix(x, 17);
        idle(3);
        do_reset(3);
        num_checks++;
        if (done_out !== 1'b0 || data_out !== 8'd0 || data_addr_out !== 10'd0) begin
            num_errors++;
            $display("FAIL midreset_clear: got done %0b data %0d addr %0d, required all 0",
                     done_out, data_out, data_addr_out);
        end
        fill_img(2);
        run_frame(0);
        test_frame_end("midreset");
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_const_frame();
        test_block();
        test_xy_pattern();
        test_gaps();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
